// File: rtl/instr_seq_pkg.sv
// Shared types and constants for the instruction sequencer.
package instr_seq_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StRun,
    StStep,
    StPause,
    StDone
  } seq_state_t;

  localparam int unsigned PC_STEP = 4;

endpackage

// File: rtl/instr_mem.sv
// Program memory: one synchronous write port, one asynchronous read port. Not reset.
module instr_mem #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic            clk_i,
  input  logic            wr_en_i,
  input  logic [AW-1:0]   wr_addr_i,
  input  logic [XLEN-1:0] wr_data_i,
  input  logic [AW-1:0]   rd_addr_i,
  output logic [XLEN-1:0] rd_data_o
);

  logic [XLEN-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/instr_sequencer.sv
// Instruction sequencer: issues a loaded program over valid/ready with run, step,
// halt/resume and loop modes. All outputs are registered from next-state values.
module instr_sequencer #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [XLEN-1:0] wr_data,
  input  logic [AW:0]     prog_len,
  input  logic            start,
  input  logic            step,
  input  logic            halt,
  input  logic            loop_en,
  output logic [XLEN-1:0] instr,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [XLEN-1:0] pc,
  output logic            busy,
  output logic            done
);
  import instr_seq_pkg::*;

  localparam int unsigned LenW = AW + 1;
  localparam logic [LenW-1:0] MaxLen = LenW'(DEPTH);

  seq_state_t      state_q, state_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic [LenW-1:0] len_q, len_d;
  logic            halt_q, halt_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            valid_q, valid_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic [XLEN-1:0] rd_data;
  logic [LenW-1:0] eff_len;
  logic            xfer, last, wr_ok, launch;

  assign wr_ok = wr_en && (state_q inside {StIdle, StPause, StDone});

  // Read port follows idx_d so the next instruction lands in instr_q with no bubble.
  instr_mem #(
    .XLEN (XLEN),
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_mem (
    .clk_i    (clk),
    .wr_en_i  (wr_ok),
    .wr_addr_i(wr_addr),
    .wr_data_i(wr_data),
    .rd_addr_i(idx_d),
    .rd_data_o(rd_data)
  );

  always_comb begin
    eff_len = (prog_len > MaxLen) ? MaxLen : prog_len;
    xfer    = valid_q && instr_ready;
    last    = ({1'b0, idx_q} == (len_q - LenW'(1)));
    // A same-cycle write wins over start/step.
    launch  = (start || step) && !wr_en;

    state_d = state_q;
    idx_d   = idx_q;
    len_d   = len_q;
    halt_d  = halt_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (launch && (eff_len != '0)) begin
          state_d = start ? StRun : StStep;
          idx_d   = '0;
          len_d   = eff_len;
          halt_d  = 1'b0;
        end
      end
      StPause: begin
        if (launch) begin
          state_d = start ? StRun : StStep;
          halt_d  = 1'b0;
        end
      end
      StRun, StStep: begin
        if ((state_q == StRun) && halt) begin
          halt_d = 1'b1;
        end
        if (xfer) begin
          idx_d = last ? '0 : idx_q + AW'(1);
          if (last && !loop_en) begin
            state_d = StDone;
            halt_d  = 1'b0;
          end else if ((state_q == StStep) || halt || halt_q) begin
            state_d = StPause;
            halt_d  = 1'b0;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    valid_d = (state_d == StRun) || (state_d == StStep);
    busy_d  = valid_d;
    done_d  = (state_d == StDone);
    instr_d = valid_d ? rd_data : '0;
    pc_d    = valid_d ? (XLEN'(idx_d) * XLEN'(PC_STEP)) : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
      len_q   <= '0;
      halt_q  <= 1'b0;
      instr_q <= '0;
      pc_q    <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      halt_q  <= halt_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign instr       = instr_q;
  assign instr_valid = valid_q;
  assign pc          = pc_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: directed scenarios plus randomized runs checked against
// a transfer-list model (program order, pc = index * 4) and a handshake-hold monitor.
module tb_instr_sequencer;
  localparam int unsigned XLEN  = 32;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = $clog2(DEPTH);

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            wr_en, start, step, halt, loop_en, instr_ready;
  logic [AW-1:0]   wr_addr;
  logic [XLEN-1:0] wr_data;
  logic [AW:0]     prog_len;
  logic [XLEN-1:0] instr, pc;
  logic            instr_valid, busy, done;

  instr_sequencer #(
    .XLEN (XLEN),
    .DEPTH(DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .prog_len   (prog_len),
    .start      (start),
    .step       (step),
    .halt       (halt),
    .loop_en    (loop_en),
    .instr      (instr),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .pc         (pc),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  int unsigned     n_checks = 0;
  int unsigned     n_fail   = 0;
  logic [XLEN-1:0] model_mem [DEPTH];
  logic [XLEN-1:0] got_pc [$];
  logic [XLEN-1:0] got_instr [$];
  logic            prev_stall = 1'b0;
  logic [XLEN-1:0] prev_instr = '0;
  logic [XLEN-1:0] prev_pc = '0;

  task automatic check_eq(input string tag, input logic [XLEN-1:0] got,
                          input logic [XLEN-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Transfers complete on the next rising edge if valid && ready holds at the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall <= 1'b0;
    end else begin
      if (prev_stall) begin
        check_eq("hold_valid", instr_valid, 1);
        check_eq("hold_instr", instr, prev_instr);
        check_eq("hold_pc", pc, prev_pc);
      end
      if (instr_valid && instr_ready) begin
        got_pc.push_back(pc);
        got_instr.push_back(instr);
      end
      prev_stall <= instr_valid && !instr_ready;
      prev_instr <= instr;
      prev_pc    <= pc;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input int a, input logic [XLEN-1:0] d);
    wr_en   = 1'b1;
    wr_addr = AW'(a);
    wr_data = d;
    model_mem[a] = d;
    cyc();
    wr_en = 1'b0;
  endtask

  task automatic load_rand(input int n);
    for (int i = 0; i < n; i++) write_word(i, $urandom);
  endtask

  task automatic wait_done(input int budget);
    for (int c = 0; c < budget && !done; c++) cyc();
    check_eq("done_reached", done, 1);
  endtask

  task automatic compare_run(input string tag, input int n);
    check_eq({tag, "_count"}, XLEN'(got_pc.size()), XLEN'(n));
    for (int i = 0; i < n && i < got_pc.size(); i++) begin
      check_eq({tag, "_pc"}, got_pc[i], XLEN'(i * 4));
      check_eq({tag, "_instr"}, got_instr[i], model_mem[i]);
    end
  endtask

  task automatic clear_log();
    got_pc.delete();
    got_instr.delete();
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  // Random run or step session with random backpressure, halts and ignored writes.
  task automatic rand_scenario();
    int len, n, mode;
    logic started, go;
    load_rand(DEPTH);
    len  = $urandom_range(1, DEPTH + 1);
    n    = (len > DEPTH) ? DEPTH : len;
    mode = $urandom_range(0, 1);
    prog_len = (AW + 1)'(len);
    loop_en  = 1'b0;
    started  = 1'b0;
    clear_log();
    for (int c = 0; c < 4000; c++) begin
      if (started && done) break;
      go          = !busy && (!done || !started);
      instr_ready = ($urandom_range(0, 3) != 0);
      halt        = (mode == 0) && ($urandom_range(0, 7) == 0);
      start       = go && (mode == 0);
      step        = go && (mode == 1);
      wr_en       = busy && ($urandom_range(0, 3) == 0);
      wr_addr     = AW'($urandom);
      wr_data     = $urandom;
      if (go) started = 1'b1;
      cyc();
    end
    start = 1'b0;
    step  = 1'b0;
    halt  = 1'b0;
    wr_en = 1'b0;
    check_eq("rand_done", done, 1);
    compare_run("rand", n);
  endtask

  initial begin
    wr_en = 1'b0; start = 1'b0; step = 1'b0; halt = 1'b0; loop_en = 1'b0;
    instr_ready = 1'b0; wr_addr = '0; wr_data = '0; prog_len = '0;

    // Reset state
    cyc();
    cyc();
    check_eq("rst_instr", instr, 0);
    check_eq("rst_valid", instr_valid, 0);
    check_eq("rst_pc", pc, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    rst = 1'b0;
    cyc();

    // Basic run
    write_word(0, 32'h015A04B3);
    write_word(1, 32'h00148593);
    prog_len = 2; instr_ready = 1'b1; clear_log();
    start = 1'b1;
    cyc();
    start = 1'b0;
    check_eq("basic_valid0", instr_valid, 1);
    check_eq("basic_instr0", instr, 32'h015A04B3);
    check_eq("basic_pc0", pc, 0);
    cyc();
    check_eq("basic_instr1", instr, 32'h00148593);
    check_eq("basic_pc1", pc, 4);
    cyc();
    check_eq("basic_done", done, 1);
    check_eq("basic_valid_end", instr_valid, 0);
    check_eq("basic_busy_end", busy, 0);

    // Backpressure
    load_rand(5);
    prog_len = 5; instr_ready = 1'b1; clear_log();
    start = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
    instr_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cyc();
      check_eq("bp_pc", pc, 4);
      check_eq("bp_valid", instr_valid, 1);
    end
    instr_ready = 1'b1;
    wait_done(50);
    compare_run("bp", 5);

    // Halt and resume
    load_rand(6);
    prog_len = 6; instr_ready = 1'b1; clear_log();
    start = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
    cyc();
    check_eq("halt_pc_before", pc, 8);
    halt = 1'b1;
    cyc();
    halt = 1'b0;
    check_eq("halt_valid", instr_valid, 0);
    check_eq("halt_busy", busy, 0);
    check_eq("halt_done", done, 0);
    cyc();
    cyc();
    check_eq("halt_still_paused", instr_valid, 0);
    check_eq("halt_xfers", XLEN'(got_pc.size()), 3);
    start = 1'b1;
    cyc();
    start = 1'b0;
    check_eq("resume_valid", instr_valid, 1);
    check_eq("resume_pc", pc, 12);
    check_eq("resume_instr", instr, model_mem[3]);
    wait_done(50);
    compare_run("halt", 6);

    // Step from IDLE
    pulse_reset();
    prog_len = 6; instr_ready = 1'b1; clear_log();
    for (int k = 0; k < 3; k++) begin
      step = 1'b1;
      cyc();
      step = 1'b0;
      check_eq("step_valid", instr_valid, 1);
      check_eq("step_pc", pc, XLEN'(k * 4));
      check_eq("step_instr", instr, model_mem[k]);
      cyc();
      check_eq("step_paused", instr_valid, 0);
      check_eq("step_busy", busy, 0);
      check_eq("step_done", done, 0);
    end
    cyc();
    compare_run("step", 3);

    // prog_len = 0 is ignored
    pulse_reset();
    prog_len = 0;
    start = 1'b1;
    cyc();
    cyc();
    start = 1'b0;
    check_eq("len0_valid", instr_valid, 0);
    check_eq("len0_busy", busy, 0);
    check_eq("len0_done", done, 0);

    // Loop
    prog_len = 3; loop_en = 1'b1; instr_ready = 1'b1; clear_log();
    start = 1'b1;
    cyc();
    start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      check_eq("loop_pc", pc, XLEN'((k % 3) * 4));
      check_eq("loop_done", done, 0);
      cyc();
    end
    loop_en = 1'b0;
    wait_done(20);

    // Length clamps to DEPTH
    load_rand(DEPTH);
    prog_len = (AW + 1)'(DEPTH + 1); instr_ready = 1'b1; clear_log();
    start = 1'b1;
    cyc();
    start = 1'b0;
    wait_done(100);
    compare_run("clamp", DEPTH);

    // Write during RUN is ignored
    load_rand(4);
    prog_len = 4; instr_ready = 1'b0; clear_log();
    start = 1'b1;
    cyc();
    start = 1'b0;
    wr_en = 1'b1; wr_addr = 2; wr_data = ~model_mem[2];
    cyc();
    wr_en = 1'b0;
    instr_ready = 1'b1;
    wait_done(50);
    compare_run("wr_run", 4);

    // Reset mid-RUN clears outputs without a clock edge
    prog_len = 4; instr_ready = 1'b0;
    start = 1'b1;
    cyc();
    start = 1'b0;
    check_eq("midrst_running", instr_valid, 1);
    #2;
    rst = 1'b1;
    #1;
    check_eq("midrst_instr", instr, 0);
    check_eq("midrst_valid", instr_valid, 0);
    check_eq("midrst_pc", pc, 0);
    check_eq("midrst_busy", busy, 0);
    check_eq("midrst_done", done, 0);
    cyc();
    rst = 1'b0;
    instr_ready = 1'b1;
    cyc();
    cyc();
    check_eq("midrst_no_restart", instr_valid, 0);

    // Randomized sessions
    for (int it = 0; it < 20; it++) rand_scenario();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

Parametrised instruction sequencer that replaces hand-timed instruction stimulus in front of `Single_datapath`. It holds a small loadable program memory and issues instructions over a valid/ready handshake with a byte PC. It supports run, single-step, halt/resume and loop modes. The sequencer sits between the program loader (bench or boot logic) and the datapath's `instr` input, in the same clock domain.

## Interface
Parameters:
- `XLEN`, 32: instruction and PC width.
- `DEPTH`, 16: program memory entries; power of two, ≥2.
- `AW`, `$clog2(DEPTH)`: derived index width; never overridden.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `wr_en`  in  1  program write strobe.
- `wr_addr`  in  AW  word index written.
- `wr_data`  in  XLEN  instruction written.
- `prog_len`  in  AW+1  number of valid instructions; sampled on start/step from IDLE or DONE.
- `start`  in  1  begin, or resume, continuous issue.
- `step`  in  1  issue exactly one instruction, then pause.
- `halt`  in  1  pause after the pending instruction is accepted.
- `loop_en`  in  1  wrap to index 0 after the last instruction instead of finishing.
- `instr`  out  XLEN  instruction presented to the datapath.
- `instr_valid`  out  1  `instr` and `pc` are valid.
- `instr_ready`  in  1  datapath accepts this cycle.
- `pc`  out  XLEN  byte address of `instr` (index × 4).
- `busy`  out  1  high in RUN and STEP.
- `done`  out  1  high in DONE.

## Operation
- States: IDLE, RUN, STEP, PAUSE, DONE.
- A transfer occurs when `instr_valid && instr_ready`.
- **IDLE:**
  - `start` with effective length ≠ 0 → RUN, index 0.
  - `step` with effective length ≠ 0 → STEP, index 0.
  - Effective length = min(`prog_len`, DEPTH), latched on this entry.
  - Effective length 0: `start`/`step` ignored; stay IDLE.
- **RUN:**
  - Presents `mem[idx]` continuously.
  - On each transfer, idx advances.
  - `halt` sets a pending flag. On the next transfer (including one in the same cycle as `halt`), go to PAUSE.
- **STEP:** presents one instruction. On its transfer → PAUSE.
- **PAUSE:**
  - `instr_valid` = 0; idx retained.
  - `start` → RUN; `step` → STEP. Both continue from idx, with the same length.
- **End of program:** a transfer at idx = len−1 has priority over halt/step pause.
  - `loop_en` = 1 → idx = 0, state unchanged (RUN keeps issuing; STEP still goes to PAUSE).
  - `loop_en` = 0 → DONE.
- **DONE:**
  - `instr_valid` = 0, `done` = 1.
  - `start`/`step` restart at idx 0 with a freshly sampled length.
- **Priorities:**
  - `start` beats `step` when both are asserted.
  - `halt` is ignored outside RUN.
- **Handshake:** once `instr_valid` rises, `instr` and `pc` are held stable until the transfer. `halt` never drops a presented instruction.
- **Writes:**
  - Accepted only in IDLE, PAUSE and DONE; ignored in RUN and STEP.
  - A write in the same cycle as `start`/`step` is performed, and the start/step is ignored that cycle.
- **Arithmetic:**
  - idx is AW bits and wraps modulo len, not DEPTH.
  - `pc` = zero-extended idx << 2.

## Timing
- **Reset values:** state IDLE, `instr` = 0, `instr_valid` = 0, `pc` = 0, `busy` = 0, `done` = 0, idx = 0, halt flag clear. Memory is not reset.
- **Start latency:** `start` sampled in cycle N → `instr_valid` = 1 with `mem[0]` and `pc` = 0 in cycle N+1.
- **Throughput:** with `instr_ready` held high, one transfer per cycle. The next instruction is registered in the cycle following each transfer, with no bubble.
- **Finish latency:** last transfer in cycle M → `done` = 1 and `instr_valid` = 0 in cycle M+1.
- **Write visibility:** a write in cycle K is visible to an issue that starts in K+1.
- **All outputs registered.**
- **Reset mid-operation:** asserting `rst` clears outputs immediately, without waiting for the clock. The next issue requires a new `start`.

## Structure
- Package `instr_seq_pkg`:
  - state enum typedef `seq_state_t`.
  - constant `PC_STEP` = 4.
- Sub-module `instr_mem`: DEPTH×XLEN register array, one synchronous write port, one asynchronous read port indexed by next-idx.
- Top level: FSM, idx/len registers, halt flag, output registers.

## Test plan
- **Basic run:** load 0x015A04B3 at index 0 and 0x00148593 at index 1, `prog_len` = 2, `start`, `instr_ready` = 1.
  - Cycle N+1: 0x015A04B3 at `pc` = 0.
  - Cycle N+2: 0x00148593 at `pc` = 4.
  - N+3: `done` = 1.
- **Backpressure:** `instr_ready` low for 3 cycles mid-program → `instr`/`pc` stable, no index skip. Each instruction is transferred exactly once.
- **Halt and resume:** `halt` during RUN at idx 2 with a simultaneous transfer → PAUSE, `instr_valid` = 0, no further transfer. `start` → resumes at `pc` = 12.
- **Step:** `step` three times from IDLE → exactly three single transfers at `pc` 0, 4, 8, with PAUSE between each.
- **Loop:** `loop_en` = 1, `prog_len` = 3 → the `pc` sequence is 0, 4, 8, 0, 4 and `done` stays 0.
- **Boundaries:**
  - `prog_len` = 0 with `start` → stays IDLE.
  - `prog_len` = DEPTH+1 → clamps to DEPTH.
  - A write during RUN is ignored.
  - `rst` mid-RUN → all outputs 0 immediately.
